sev_seg_scan_ctrl: RTL and testbench

Sequencing controller for the calculator's seven-segment decoder. It captures a signed calculator result and its operator select through a load/busy handshake. It converts the magnitude to BCD with a multi-cycle shift-add-3 state machine, then time-multiplexes the four digit positions at a programmable refresh rate. It drives the decoder's `a`, `x`, `isNeg` and `sel` inputs; digit data is double-buffered, so the scan never shows a half-converted value.

---
 rtl/sev_seg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_ctrl.sv
// rtl/sev_seg_scan_ctrl.sv - load/convert/commit sequencer and digit scanner for the seven-segment decoder
//
// Captures a signed 11-bit result plus operator select, converts the magnitude
// to BCD with an iterative shift-add-3 engine, and commits the digits into a
// display buffer that a free-running scanner multiplexes onto the decoder.
//
// Optional feature: define SEVSEG_SAT_EN to force the committed digits to 9,9,9
// whenever the magnitude exceeds 999; otherwise the low three BCD digits are shown.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   load    in   capture request, honoured only while idle
//   value   in   [10:0] signed two's-complement result
//   sel_in  in   [2:0] operator select captured with value
//   busy    out  conversion in progress
//   done    out  one-cycle pulse when new digits are committed
//   ovf     out  committed magnitude exceeded 999
//   a       out  [1:0] digit position select
//   x       out  [3:0] BCD digit for position a
//   isNeg   out  committed sign
//   sel     out  [2:0] committed operator select

module sev_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [10:0] value,
  input  logic [2:0]  sel_in,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [1:0]  a,
  output logic [3:0]  x,
  output logic        isNeg,
  output logic [2:0]  sel
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] LAST_ITER = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  state_t state_q, state_d;

  logic        capture;
  logic        step;
  logic        commit;

  logic [10:0] mag_q;
  logic [15:0] bcd_q;
  logic [3:0]  iter_q;
  logic        sign_q;
  logic [2:0]  sel_cap_q;
  logic [10:0] mag_abs;

  logic [3:0]  dig_h_q, dig_t_q, dig_o_q;
  logic [3:0]  dig_h_c, dig_t_c, dig_o_c;
  logic        ovf_c;
  logic        is_zero;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;
  logic [1:0]       a_next;
  logic [3:0]       x_next;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    capture = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        busy = 1'b1;
        step = 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        busy    = 1'b1;
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add-3 binary to BCD engine
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Two's-complement negate in 11 bits; -1024 wraps to 11'h400, which read as
  // unsigned is exactly the 1024 magnitude we want.
  assign mag_abs = value[10] ? (~value + 11'd1) : value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      sign_q    <= 1'b0;
      sel_cap_q <= '0;
    end else if (capture) begin
      mag_q     <= mag_abs;
      bcd_q     <= '0;
      iter_q    <= '0;
      sign_q    <= value[10];
      sel_cap_q <= sel_in;
    end else if (step) begin
      {bcd_q, mag_q} <= {bcd_adjust(bcd_q), mag_q} << 1;
      iter_q         <= iter_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit into the display buffer
  // ---------------------------------------------------------------------------
  assign ovf_c   = (bcd_q[15:12] != 4'd0);
  assign is_zero = (bcd_q == 16'd0);

`ifdef SEVSEG_SAT_EN
  assign dig_h_c = ovf_c ? 4'd9 : bcd_q[11:8];
  assign dig_t_c = ovf_c ? 4'd9 : bcd_q[7:4];
  assign dig_o_c = ovf_c ? 4'd9 : bcd_q[3:0];
`else
  assign dig_h_c = bcd_q[11:8];
  assign dig_t_c = bcd_q[7:4];
  assign dig_o_c = bcd_q[3:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_h_q <= '0;
      dig_t_q <= '0;
      dig_o_q <= '0;
      isNeg   <= 1'b0;
      sel     <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        dig_h_q <= dig_h_c;
        dig_t_q <= dig_t_c;
        dig_o_q <= dig_o_c;
        // A zero result never shows a minus sign.
        isNeg   <= sign_q & ~is_zero;
        sel     <= sel_cap_q;
        ovf     <= ovf_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scanner
  // ---------------------------------------------------------------------------
  assign wrap = (cnt_q == CNT_MAX);

  // Position order 1 -> 0 -> 3 -> 2 -> 1 is simply a modulo-4 decrement.
  assign a_next = wrap ? (a - 2'd1) : a;

  // x is registered, so it is loaded with the digit for the position that a
  // will hold after this edge.
  always_comb begin
    x_next = 4'd0;
    case (a_next)
      2'd1:    x_next = 4'd0;
      2'd0:    x_next = dig_h_q;
      2'd3:    x_next = dig_t_q;
      2'd2:    x_next = dig_o_q;
      default: x_next = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      a     <= 2'd1;
      x     <= 4'd0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      a     <= a_next;
      x     <= x_next;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb/tb_sev_seg_scan_ctrl.sv - randomized self-checking bench for sev_seg_scan_ctrl

module tb_sev_seg_scan_ctrl;

  localparam int RDIV = 4;

`ifdef SEVSEG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               load;
  logic signed [10:0] value;
  logic [2:0]         sel_in;
  logic               busy;
  logic               done;
  logic               ovf;
  logic [1:0]         a;
  logic [3:0]         x;
  logic               isNeg;
  logic [2:0]         sel;

  int tests;
  int fails;

  sev_seg_scan_ctrl #(.REFRESH_DIV(RDIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .value  (value),
    .sel_in (sel_in),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .a      (a),
    .x      (x),
    .isNeg  (isNeg),
    .sel    (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: edge counting and decimal arithmetic
  // ---------------------------------------------------------------------------
  int       order [4] = '{1, 0, 3, 2};
  int       m_scan;
  int       m_a, m_x;
  int       m_h, m_t, m_o;
  bit       m_busy, m_done, m_ovf, m_neg;
  int       m_sel;
  bit       m_active;
  int       m_steps;
  int       m_val, m_cap_sel;
  bit       checking;

  function automatic int digit_at(int pos);
    case (pos)
      0: return m_h;
      3: return m_t;
      2: return m_o;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_scan = 0; m_a = 1; m_x = 0;
    m_h = 0; m_t = 0; m_o = 0;
    m_busy = 0; m_done = 0; m_ovf = 0; m_neg = 0; m_sel = 0;
    m_active = 0; m_steps = 0;
  endtask

  task automatic model_commit();
    int mag;
    mag   = (m_val < 0) ? -m_val : m_val;
    m_ovf = (mag > 999);
    m_neg = (m_val < 0);
    m_sel = m_cap_sel;
    if (SAT && m_ovf) begin
      m_h = 9; m_t = 9; m_o = 9;
    end else begin
      m_h = (mag / 100) % 10;
      m_t = (mag / 10) % 10;
      m_o = mag % 10;
    end
  endtask

  initial begin
    model_reset();
    checking = 1'b1;
  end

  always begin : compare_proc
    bit r_s, l_s;
    int v_s, s_s;
    @(posedge clk);
    r_s = rst_n; l_s = load; v_s = value; s_s = sel_in;
    #1;
    if (checking) begin
      if (!r_s) begin
        model_reset();
      end else begin
        m_scan = (m_scan + 1) % (4 * RDIV);
        m_a    = order[m_scan / RDIV];
        m_x    = digit_at(m_a);
        m_done = 0;
        if (m_active) begin
          m_steps++;
          if (m_steps == 12) begin
            model_commit();
            m_done   = 1;
            m_active = 0;
          end
        end else if (l_s) begin
          m_active  = 1;
          m_steps   = 0;
          m_val     = v_s;
          m_cap_sel = s_s;
        end
        m_busy = m_active;
      end
      chk("a", a, m_a);
      chk("x", x, m_x);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("ovf", ovf, m_ovf);
      chk("isNeg", isNeg, m_neg);
      chk("sel", sel, m_sel);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic do_load(input int v, input int s);
    value  = 11'(v);
    sel_in = 3'(s);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_digits(input int h, input int t, input int o);
    int e;
    chk("model_h", m_h, h);
    chk("model_t", m_t, t);
    chk("model_o", m_o, o);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4 * RDIV; i++) begin
      case (a)
        2'd0: e = h;
        2'd3: e = t;
        2'd2: e = o;
        default: e = 0;
      endcase
      chk("scan_digit", x, e);
      @(negedge clk);
    end
  endtask

  task automatic load_and_check(input int v, input int s, input int h, input int t,
                                input int o, input int neg, input int of);
    int n;
    do_load(v, s);
    chk("busy_after_load", busy, 1);
    wait_done(20, n);
    chk("done_latency", n, 12);
    chk("busy_at_done", busy, 0);
    chk("isNeg_commit", isNeg, neg);
    chk("sel_commit", sel, s);
    chk("ovf_commit", ovf, of);
    check_digits(h, t, o);
  endtask

  int exp_scan [4] = '{0, 3, 2, 1};

  initial begin : main
    int n, dcnt;
    rst_n = 1'b0; load = 1'b0; value = '0; sel_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int p = 0; p < 4; p++) begin
      repeat (RDIV) @(negedge clk);
      chk("scan_order", a, exp_scan[p]);
    end

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_a", a, 1);
    chk("rst_x", x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_isNeg", isNeg, 0);
    chk("rst_sel", sel, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    load_and_check(123, 3, 1, 2, 3, 0, 0);
    load_and_check(-45, 5, 0, 4, 5, 1, 0);
    load_and_check(0, 1, 0, 0, 0, 0, 0);
    if (SAT) begin
      load_and_check(1023, 6, 9, 9, 9, 0, 1);
      load_and_check(-1024, 7, 9, 9, 9, 1, 1);
    end else begin
      load_and_check(1023, 6, 0, 2, 3, 0, 1);
      load_and_check(-1024, 7, 0, 2, 4, 1, 1);
    end

    // Load during conversion is ignored.
    do_load(500, 2);
    repeat (4) @(negedge clk);
    value = 11'sd7; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("ignored_load_done_count", dcnt, 1);
    check_digits(5, 0, 0);

    // Reset part-way through a conversion.
    do_load(321, 4);
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_x", x, 0);
    chk("abort_sel", sel, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);
    check_digits(0, 0, 0);
    load_and_check(321, 4, 3, 2, 1, 0, 0);

    // Back-to-back loads with load held high.
    value = 11'sd77; sel_in = 3'd1; load = 1'b1;
    @(negedge clk);
    wait_done(20, n);
    chk("b2b_first", n, 12);
    @(negedge clk);
    wait_done(20, n);
    chk("b2b_gap", n + 1, 13);
    load = 1'b0;
    repeat (20) @(negedge clk);

    // Randomized traffic, including corner values and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0: value = -11'sd1024;
        1: value = 11'sd1023;
        2: value = 11'sd0;
        3: value = 11'sd999;
        4: value = -11'sd1000;
        default: value = 11'($urandom);
      endcase
      sel_in = 3'($urandom);
      rst_n  = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; load = 1'b0;
    repeat (20) @(negedge clk);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
